// File: rtl/masked_affine_pkg.sv
// Shared definitions for the masked affine layer: mode encodings, the
// polynomial-to-normal-basis row masks, the AES affine constant and the
// per-share 8-bit map used by every share lane.
package masked_affine_pkg;

  typedef enum logic [1:0] {
    MODE_BASIS  = 2'd0,
    MODE_AES    = 2'd1,
    MODE_BYPASS = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // ROW_IN[k] selects the input bits whose parity forms output bit k.
  localparam logic [7:0][7:0] ROW_IN = {
    8'hE7, 8'h71, 8'h63, 8'hE1, 8'h9B, 8'h01, 8'h61, 8'h4F
  };

  localparam logic [7:0] AES_C = 8'h63;

  // Linear map for one share. The AES constant is added only on share 0 so
  // the recombined value picks it up exactly once for any share count.
  function automatic logic [7:0] affine8(input logic [7:0] a,
                                         input mode_e      mode,
                                         input logic       is_share0);
    logic [7:0] b;
    b = a;
    case (mode)
      MODE_BASIS: begin
        for (int k = 0; k < 8; k++) begin
          b[k] = ^(a & ROW_IN[k]);
        end
      end
      MODE_AES: begin
        // Bit i collects a[i], a[i+4..i+7]: the rotate-right terms by 4..7.
        b = a ^ {a[3:0], a[7:4]} ^ {a[4:0], a[7:5]}
              ^ {a[5:0], a[7:6]} ^ {a[6:0], a[7]};
        if (is_share0) begin
          b = b ^ AES_C;
        end
      end
      default: b = a;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/affine_share_map.sv
// Purpose : combinational GF(2) map of one 8-bit share (basis change, AES
//           affine or bypass); CONST_EN adds the AES constant on this lane.
// Ports   : a (share in), mode (map select), b (share out). Latency 0.
module affine_share_map
  import masked_affine_pkg::*;
#(
  parameter bit CONST_EN = 1'b0
) (
  input  logic [7:0] a,
  input  logic [1:0] mode,
  output logic [7:0] b
);

  assign b = affine8(a, mode_e'(mode), CONST_EN);

endmodule

// File: rtl/masked_affine_layer.sv
// Purpose : share-wise affine/basis map of a masked byte, optional mask
//           refresh, then a 2-entry skid buffer with registered in_ready.
// Latency : 1 cycle from input handshake to out_valid.
// Backpressure: output holds while out_valid & !out_ready; in_ready drops
//           (registered) once both entries are occupied.
// Ports   : in_valid/in_ready/in_mode/in_shares/rnd on the input side,
//           out_valid/out_ready/out_shares/out_mode on the output side.
module masked_affine_layer
  import masked_affine_pkg::*;
#(
  parameter int NSHARES = 2,
  parameter int REFRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_mode,
  input  logic [8*NSHARES-1:0]       in_shares,
  input  logic [8*(NSHARES-1)-1:0]   rnd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*NSHARES-1:0]       out_shares,
  output logic [1:0]                 out_mode
);

  localparam int SW = 8 * NSHARES;

  logic [SW-1:0] mapped;
  logic [SW-1:0] fresh;
  logic [7:0]    rnd_sum;

  // One independent lane per share; nothing here mixes shares.
  for (genvar gi = 0; gi < NSHARES; gi++) begin : g_share
    affine_share_map #(
      .CONST_EN (gi == 0)
    ) u_map (
      .a    (in_shares[8*gi +: 8]),
      .mode (in_mode),
      .b    (mapped[8*gi +: 8])
    );
  end

  // Refresh: each of the first NSHARES-1 shares takes its own rnd byte and
  // the last share takes the XOR of all of them, so the recombined value is
  // unchanged. The only cross-lane term is built from rnd alone.
  always_comb begin
    fresh   = mapped;
    rnd_sum = '0;
    if (REFRESH != 0) begin
      for (int i = 0; i < NSHARES - 1; i++) begin
        fresh[8*i +: 8] = mapped[8*i +: 8] ^ rnd[8*i +: 8];
        rnd_sum         = rnd_sum ^ rnd[8*i +: 8];
      end
      fresh[SW-1 -: 8] = mapped[SW-1 -: 8] ^ rnd_sum;
    end
  end

  // Skid buffer: the head entry is the output register itself, ent1 holds
  // the second beat. count is the number of valid entries.
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [SW-1:0] ent1_shares;
  logic [1:0]    ent1_mode;
  logic          push;
  logic          pop;

  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 2'd1;
    end else if (pop && !push) begin
      count_nxt = count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      in_ready    <= 1'b0;
      out_shares  <= '0;
      out_mode    <= 2'd0;
      ent1_shares <= '0;
      ent1_mode   <= 2'd0;
    end else begin
      count    <= count_nxt;
      // Registered from next occupancy: no path from out_ready to in_ready.
      in_ready <= (count_nxt != 2'd2);
      if (push) begin
        // New beat goes straight to the head when the head is free or is
        // leaving this cycle; otherwise it parks in the second entry.
        if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          out_shares <= fresh;
          out_mode   <= in_mode;
        end else begin
          ent1_shares <= fresh;
          ent1_mode   <= in_mode;
        end
      end else if (pop && (count == 2'd2)) begin
        out_shares <= ent1_shares;
        out_mode   <= ent1_mode;
      end
    end
  end

endmodule

// File: tb/tb_masked_affine_layer.sv
// Bench for masked_affine_layer: three instances in lockstep
// (2 shares/no refresh, 3 shares/no refresh, 3 shares/refresh), directed
// hand-computed vectors, then scoreboarded random, backpressure, streaming
// and reset-with-data scenarios.
module tb_masked_affine_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  in_mode;
  logic [23:0] in_shares;
  logic [15:0] rnd;

  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out;
  logic [1:0]  a_mode;
  logic        b_in_ready, b_out_valid;
  logic [23:0] b_out;
  logic [1:0]  b_mode;
  logic        c_in_ready, c_out_valid;
  logic [23:0] c_out;
  logic [1:0]  c_mode;

  always #5 clk = ~clk;

  masked_affine_layer #(.NSHARES(2), .REFRESH(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_mode(in_mode), .in_shares(in_shares[15:0]), .rnd(rnd[7:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_shares(a_out),
    .out_mode(a_mode)
  );

  masked_affine_layer #(.NSHARES(3), .REFRESH(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_mode(in_mode), .in_shares(in_shares), .rnd(rnd),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_shares(b_out),
    .out_mode(b_mode)
  );

  masked_affine_layer #(.NSHARES(3), .REFRESH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_mode(in_mode), .in_shares(in_shares), .rnd(rnd),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_shares(c_out),
    .out_mode(c_mode)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [63:0] ROWS = {8'hE7, 8'h71, 8'h63, 8'hE1,
                                  8'h9B, 8'h01, 8'h61, 8'h4F};

  function automatic logic [7:0] lin(input logic [1:0] m, input logic [7:0] x);
    logic [7:0]  r;
    logic [63:0] rows;
    rows = ROWS;
    r    = x;
    if (m == 2'd0) begin
      for (int k = 0; k < 8; k++) r[k] = ^(x & rows[8*k +: 8]);
    end else if (m == 2'd1) begin
      for (int i = 0; i < 8; i++) begin
        r[i] = x[3'(i)];
        for (int d = 4; d < 8; d++) r[i] = r[i] ^ x[3'(i + d)];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] unm(input logic [1:0] m, input logic [7:0] x);
    return lin(m, x) ^ ((m == 2'd1) ? 8'h63 : 8'h00);
  endfunction

  function automatic logic [7:0] x3(input logic [23:0] s);
    return s[7:0] ^ s[15:8] ^ s[23:16];
  endfunction

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] a_sh;
    logic [23:0] b_sh;
    logic [23:0] c_sh;
    logic [7:0]  c_x;
  } exp_t;

  function automatic exp_t model(input logic [1:0] m, input logic [23:0] s,
                                 input logic [15:0] r);
    exp_t       e;
    logic [7:0] b0, b1, b2;
    b0     = unm(m, s[7:0]);
    b1     = lin(m, s[15:8]);
    b2     = lin(m, s[23:16]);
    e.mode = m;
    e.a_sh = {b1, b0};
    e.b_sh = {b2, b1, b0};
    e.c_sh = {b2 ^ r[7:0] ^ r[15:8], b1 ^ r[15:8], b0 ^ r[7:0]};
    e.c_x  = unm(m, x3(s));
    return e;
  endfunction

  // ---------------- scoreboard monitor ----------------
  exp_t sbq[$];
  logic mon_en   = 1'b0;
  int   push_cnt = 0;
  int   pop_cnt  = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && rst_n) begin
      if (c_out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check_eq("spurious_out", 32'(c_out_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          pop_cnt++;
          check_eq("sb_a_shares", 32'(a_out), 32'(e.a_sh));
          check_eq("sb_b_shares", 32'(b_out), 32'(e.b_sh));
          check_eq("sb_c_shares", 32'(c_out), 32'(e.c_sh));
          check_eq("sb_c_xor", 32'(x3(c_out)), 32'(e.c_x));
          check_eq("sb_mode", 32'(c_mode), 32'(e.mode));
        end
      end
      if (in_valid && c_in_ready) begin
        sbq.push_back(model(in_mode, in_shares, rnd));
        push_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_rand();
    in_mode   = 2'($urandom_range(3));
    in_shares = 24'($urandom);
    rnd       = 16'($urandom);
  endtask

  // One isolated beat with out_ready=1; returns at the negedge where the
  // beat is on the output.
  task automatic send1(input logic [1:0] m, input logic [23:0] s,
                       input logic [15:0] r);
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = m; in_shares = s; rnd = r;
    @(negedge clk);
    check_eq("send_rdy", 32'(c_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("latency_vld", 32'(c_out_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_bad, vld_cnt, cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 2'd0; in_shares = '0; rnd = '0;
    #12;
    check_eq("rst_vld", 32'(c_out_valid), 32'd0);
    check_eq("rst_shares", 32'(c_out), 32'd0);
    check_eq("rst_mode", 32'(c_mode), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rdy", 32'(c_in_ready), 32'd1);

    // ---- directed, hand-computed ----
    send1(2'd0, 24'h00_01_00, 16'h0000);
    check_eq("m0_a_xor_ff", 32'(a_out[7:0] ^ a_out[15:8]), 32'hFF);
    check_eq("m0_a_shares", 32'(a_out), 32'hFF00);
    check_eq("m0_a_mode", 32'(a_mode), 32'd0);
    @(negedge clk);
    check_eq("empty_vld", 32'(a_out_valid), 32'd0);
    check_eq("empty_hold", 32'(a_out), 32'hFF00);

    send1(2'd0, 24'h00_00_80, 16'h0000);
    check_eq("m0_a_xor_98", 32'(a_out[7:0] ^ a_out[15:8]), 32'h98);
    check_eq("m0_a_shares2", 32'(a_out), 32'h0098);

    send1(2'd1, 24'h68_33_5A, 16'hA55A);
    check_eq("m1_b_xor_7c", 32'(x3(b_out)), 32'h7C);
    check_eq("m1_b_shares", 32'(b_out), 32'hDC_33_93);
    check_eq("m1_c_shares", 32'(c_out), 32'h23_96_C9);
    check_eq("m1_c_xor_7c", 32'(x3(c_out)), 32'h7C);
    check_eq("m1_mode", 32'(c_mode), 32'd1);

    send1(2'd1, 24'h33_22_11, 16'h0000);
    check_eq("m1_b_xor_63", 32'(x3(b_out)), 32'h63);
    check_eq("m1_b_share2", 32'(b_out[23:16]), 32'h33);
    check_eq("m1_c_xor_63", 32'(x3(c_out)), 32'h63);

    send1(2'd3, 24'hC0_FF_EE, 16'h0000);
    check_eq("m3_bypass", 32'(b_out), 32'hC0FFEE);
    check_eq("m3_mode", 32'(b_mode), 32'd3);
    @(negedge clk);

    // ---- random scoreboarded traffic ----
    mon_en = 1'b1;
    cyc = 0;
    while (push_cnt < 1000 && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
      drive_rand();
      in_valid  = (push_cnt < 1000) && ($urandom_range(4) != 0);
      out_ready = ($urandom_range(3) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("rand_pushes", 32'(push_cnt), 32'd1000);
    repeat (4) @(negedge clk);
    check_eq("rand_drain", 32'(sbq.size()), 32'd0);

    // ---- backpressure ----
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; drive_rand();
    @(negedge clk); check_eq("bp_rdy0", 32'(c_in_ready), 32'd1);
    @(posedge clk); #1; drive_rand();
    @(negedge clk); check_eq("bp_rdy1", 32'(c_in_ready), 32'd1);
    check_eq("bp_vld", 32'(c_out_valid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; drive_rand();
      @(negedge clk);
      check_eq("bp_full", 32'(c_in_ready), 32'd0);
      check_eq("bp_hold", 32'(c_out), 32'(sbq[0].c_sh));
    end
    @(posedge clk); #1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; drive_rand();
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("bp_drain", 32'(sbq.size()), 32'd0);
    check_eq("bp_count", 32'(pop_cnt), 32'(push_cnt));

    // ---- continuous streaming ----
    rdy_bad = 0; vld_cnt = 0;
    @(posedge clk); #1; in_valid = 1'b1; drive_rand();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i < 16 && !c_in_ready) rdy_bad++;
      if (i >= 1 && c_out_valid) vld_cnt++;
      @(posedge clk); #1;
      if (i < 15) drive_rand();
      else in_valid = 1'b0;
    end
    check_eq("stream_rdy", 32'(rdy_bad), 32'd0);
    check_eq("stream_vld", 32'(vld_cnt), 32'd16);
    repeat (2) @(negedge clk);
    check_eq("stream_drain", 32'(sbq.size()), 32'd0);

    // ---- reset with two beats buffered ----
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; drive_rand();
    @(posedge clk); #1; drive_rand();
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_vld", 32'(c_out_valid), 32'd1);
    #2; rst_n = 1'b0; #1;
    check_eq("arst_vld", 32'(c_out_valid), 32'd0);
    check_eq("arst_a_vld", 32'(a_out_valid), 32'd0);
    check_eq("arst_shares", 32'(c_out), 32'd0);
    mon_en = 1'b0;
    sbq.delete();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy", 32'(c_in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("no_stale", 32'(c_out_valid), 32'd0);
      @(negedge clk);
    end
    push_cnt = 0; pop_cnt = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; in_valid = 1'b1; drive_rand();
    end
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_pops", 32'(pop_cnt), 32'd4);
    check_eq("post_rst_drain", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/masked_affine_layer.md
Name: masked_affine_layer

Overview:
- Parametrised, pipelined linear/affine layer for Boolean-masked AES S-box datapaths with NSHARES shares.
- Applies one of three runtime-selectable GF(2) maps share-wise:
  - input basis change (polynomial → Canright normal basis);
  - AES output affine (matrix plus 0x63);
  - bypass.
- Optionally refreshes the masking, then buffers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Sits in front of and behind the nonlinear inversion core.

Parameters:
- NSHARES, 2, number of Boolean shares (2..4).
- REFRESH, 1, 1 = XOR fresh randomness into shares before output; 0 = rnd ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_mode  in  2  0 = basis change, 1 = AES affine, 2 = bypass, 3 = reserved (treated as bypass)
- in_shares  in  8*NSHARES  share i at bits [8i+7:8i]
- rnd  in  8*(NSHARES-1)  fresh randomness, sampled on input handshake
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_shares  out  8*NSHARES  transformed shares
- out_mode  out  2  mode carried with the beat

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_shares=0, out_mode=0, skid buffer empty, in_ready=1 from the first clock edge after release.
  - Reset mid-transfer drops every buffered beat, with no partial output.
- Mode 0, linear, applied identically to every share. Out bit k = XOR of the input bits selected by row mask ROW_IN[k] (msb first):
  - k7=0xE7, k6=0x71, k5=0x63, k4=0xE1, k3=0x9B, k2=0x01, k1=0x61, k0=0x4F.
  - No constant.
- Mode 1, AES affine: b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7) (indices mod 8), applied to every share.
  - Constant 0x63 is XORed into share 0 only, so the unmasked sum is correct for any NSHARES, odd or even.
- Modes 2/3: identity.
- Refresh (REFRESH=1): after the map, share i ^= rnd[8i+7:8i] for i < NSHARES-1, and the last share ^= XOR of all rnd bytes.
  - XOR of the shares is unchanged.
- Latency: 1 cycle. A beat accepted on edge t (in_valid & in_ready) appears with out_valid=1 after edge t.
- Handshake:
  - Output holds stable while out_valid & !out_ready.
  - No combinational path from out_ready to in_ready: in_ready is registered and equals "skid buffer not full".
  - Buffer has 2 entries, so it sustains 1 beat/cycle under continuous out_ready=1.
  - Simultaneous push and pop: occupancy unchanged, order preserved (FIFO).
  - Full, with out_ready=0: in_ready=0 and in_valid is ignored.
  - Empty: out_valid=0 and out_shares holds its last value.
- in_mode and rnd are sampled only on the input handshake; the mode travels with its beat to out_mode.
- Masking security: the map is share-local and registered before any recombination. No cross-share XOR occurs except the refresh term, which involves only rnd.

Decomposition:
- Package masked_affine_pkg holds:
  - mode encodings MODE_BASIS, MODE_AES, MODE_BYPASS;
  - ROW_IN[7:0] row masks;
  - AES_C = 8'h63;
  - function affine8(byte, mode, is_share0).
- One sub-module, affine_share_map: a single 8-bit combinational map with a share-0 constant-enable. It is instantiated NSHARES times via generate.
- The skid buffer stays inline.

Test Plan:
- NSHARES=2, REFRESH=0, mode 0, shares {0x00, 0x01} → XOR(out)=0xFF; shares {0x80, 0x00} → XOR(out)=0x98; out_valid one cycle after accept.
- NSHARES=3, mode 1, shares XOR to 0x01 (e.g. 0x5A, 0x33, 0x68) → XOR(out)=0x7C; shares XOR to 0x00 → 0x63. Confirms the constant lands in share 0 only.
- REFRESH=1, random rnd, 1000 random beats in all modes → XOR(out) matches the unmasked model; out_shares differ from the REFRESH=0 result whenever rnd≠0.
- Backpressure: out_ready=0 for 4 cycles while streaming → in_ready drops after 2 accepted beats, out_shares stable; release → beats drain in order with no loss or duplication.
- Continuous in_valid=out_ready=1 for 16 beats → 16 outputs on 16 consecutive cycles, in_ready stays 1.
- Assert rst_n=0 with 2 beats buffered → out_valid=0 immediately (async); after release, in_ready=1 and no stale beat appears.
